// File: rtl/simd_vmem_pkg.sv
// simd_vmem_pkg
//   Shared types and constants for the per-lane banked vector scratchpad.
//   - clr_state_t       : clear-engine FSM state (IDLE, CLEAR)
//   - MIN/MAX_READ_LATENCY : legal bounds of the registered read pipeline
//   - DEFAULT_ADDR_WIDTH   : default per-bank address width
//   - vmem_depth()         : bank depth (words) for a given address width
package simd_vmem_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   localparam int unsigned MIN_READ_LATENCY   = 1;
   localparam int unsigned MAX_READ_LATENCY   = 4;
   localparam int unsigned DEFAULT_ADDR_WIDTH = 10;

   function automatic int unsigned vmem_depth(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

endpackage

// File: rtl/simd_vmem_lane_bank.sv
// simd_vmem_lane_bank
//   One lane's storage bank: simple dual-port RAM with a same-address
//   write-first bypass and a READ_LATENCY-deep valid/data pipeline.
//   Ports:
//     clk, reset            : clock, synchronous active-low reset
//     rd_en, rd_addr        : accepted read request for this lane
//     wr_en, wr_addr, wr_data : write port (already muxed with clear writes)
//     rd_data, rd_valid     : pipelined read result; rd_data holds when idle
module simd_vmem_lane_bank
   import simd_vmem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid
);

   localparam int unsigned DEPTH = vmem_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  v_pipe [READ_LATENCY];
   logic [DATA_WIDTH-1:0] d_pipe [READ_LATENCY];
   logic                  bypass;

   assign bypass = rd_en && wr_en && (rd_addr == wr_addr);

   // Storage carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Each data stage only loads when a valid word enters it, so the last
   // stage keeps presenting the most recent result between reads.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned k = 0; k < READ_LATENCY; k++) begin
            v_pipe[k] <= 1'b0;
            d_pipe[k] <= '0;
         end
      end else begin
         v_pipe[0] <= rd_en;
         if (rd_en) begin
            d_pipe[0] <= bypass ? wr_data : mem[rd_addr];
         end
         for (int unsigned k = 1; k < READ_LATENCY; k++) begin
            v_pipe[k] <= v_pipe[k-1];
            if (v_pipe[k-1]) begin
               d_pipe[k] <= d_pipe[k-1];
            end
         end
      end
   end

   assign rd_data  = d_pipe[READ_LATENCY-1];
   assign rd_valid = v_pipe[READ_LATENCY-1];

endmodule

// File: rtl/simd_vector_memory.sv
// simd_vector_memory
//   Per-lane banked vector scratchpad with a hardware clear engine.
//   Ports:
//     clk, reset              : clock, synchronous active-low reset
//     read_req/read_addr      : per-lane read enable / address
//     read_data/read_valid    : per-lane pipelined read result
//     write_req/write_addr/write_data : per-lane write port
//     clear_start             : request a full clear of every bank
//     busy                    : clear in progress, requests are dropped
//     clear_done              : one-cycle pulse after the last clear write
module simd_vector_memory
   import simd_vmem_pkg::*;
#(
   parameter int unsigned           NUM_ELEM     = 64,
   parameter int unsigned           DATA_WIDTH   = 16,
   parameter int unsigned           ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
   parameter int unsigned           READ_LATENCY = 2,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0,
   parameter bit                    INIT_CLEAR   = 1'b1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_ELEM-1:0]            read_req,
   input  logic [ADDR_WIDTH*NUM_ELEM-1:0] read_addr,
   output logic [DATA_WIDTH*NUM_ELEM-1:0] read_data,
   output logic [NUM_ELEM-1:0]            read_valid,
   input  logic [NUM_ELEM-1:0]            write_req,
   input  logic [ADDR_WIDTH*NUM_ELEM-1:0] write_addr,
   input  logic [DATA_WIDTH*NUM_ELEM-1:0] write_data,
   input  logic                           clear_start,
   output logic                           busy,
   output logic                           clear_done
);

   if ((READ_LATENCY < MIN_READ_LATENCY) || (READ_LATENCY > MAX_READ_LATENCY)) begin : g_bad_latency
      $error("simd_vector_memory: READ_LATENCY %0d outside %0d..%0d",
             READ_LATENCY, MIN_READ_LATENCY, MAX_READ_LATENCY);
   end
   if (ADDR_WIDTH < 1) begin : g_bad_depth
      $error("simd_vector_memory: ADDR_WIDTH must be at least 1");
   end

   clr_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
   logic                  done_q, done_d;
   logic                  init_pending_q;
   logic                  clearing;
   logic                  accept;

   // init_pending_q is loaded while reset is held and consumed on the first
   // released cycle, which gives the automatic clear after every reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         clr_addr_q     <= '0;
         done_q         <= 1'b0;
         init_pending_q <= INIT_CLEAR;
      end else begin
         state_q        <= state_d;
         clr_addr_q     <= clr_addr_d;
         done_q         <= done_d;
         init_pending_q <= 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear_start || init_pending_q) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
            end
         end
         CLEAR: begin
            if (clr_addr_q == '1) begin
               state_d    = IDLE;
               clr_addr_d = '0;
               done_d     = 1'b1;
            end else begin
               clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy       = (state_q == CLEAR);
   assign clear_done = done_q;
   assign clearing   = busy && reset;
   assign accept     = reset && !busy;

   for (genvar i = 0; i < NUM_ELEM; i++) begin : g_lane
      logic                  lane_we;
      logic                  lane_re;
      logic [ADDR_WIDTH-1:0] lane_waddr;
      logic [DATA_WIDTH-1:0] lane_wdata;

      assign lane_re    = read_req[i] && accept;
      assign lane_we    = clearing || (write_req[i] && accept);
      assign lane_waddr = clearing ? clr_addr_q  : write_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign lane_wdata = clearing ? CLEAR_VALUE : write_data[i*DATA_WIDTH +: DATA_WIDTH];

      simd_vmem_lane_bank #(
         .DATA_WIDTH  (DATA_WIDTH),
         .ADDR_WIDTH  (ADDR_WIDTH),
         .READ_LATENCY(READ_LATENCY)
      ) u_bank (
         .clk     (clk),
         .reset   (reset),
         .rd_en   (lane_re),
         .rd_addr (read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
         .wr_en   (lane_we),
         .wr_addr (lane_waddr),
         .wr_data (lane_wdata),
         .rd_data (read_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .rd_valid(read_valid[i])
      );
   end

endmodule

// File: tb/tb_simd_vector_memory.sv
// tb_simd_vector_memory
//   Self-checking bench for simd_vector_memory (4 lanes, 16-bit data,
//   16-entry banks, read latency 2, automatic clear after reset).
module tb_simd_vector_memory;

   localparam int NE = 4;
   localparam int DW = 16;
   localparam int AW = 4;
   localparam int RL = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [NE-1:0]     read_req = '0;
   logic [AW*NE-1:0]  read_addr = '0;
   logic [DW*NE-1:0]  read_data;
   logic [NE-1:0]     read_valid;
   logic [NE-1:0]     write_req = '0;
   logic [AW*NE-1:0]  write_addr = '0;
   logic [DW*NE-1:0]  write_data = '0;
   logic              clear_start = 1'b0;
   logic              busy;
   logic              clear_done;

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } sb_t;
   sb_t sbq [NE][$];

   typedef struct {
      logic [NE-1:0]    wr_en;
      logic [AW*NE-1:0] wr_addr;
      logic [DW*NE-1:0] wr_data;
      logic [NE-1:0]    rd_en;
      logic [AW*NE-1:0] rd_addr;
      logic [DW*NE-1:0] exp_data;
   } vec_t;
   vec_t vecs [9];

   simd_vector_memory #(
      .NUM_ELEM    (NE),
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .READ_LATENCY(RL),
      .CLEAR_VALUE (16'h0000),
      .INIT_CLEAR  (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .read_req   (read_req),
      .read_addr  (read_addr),
      .read_data  (read_data),
      .read_valid (read_valid),
      .write_req  (write_req),
      .write_addr (write_addr),
      .write_data (write_data),
      .clear_start(clear_start),
      .busy       (busy),
      .clear_done (clear_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      read_req    = '0;
      write_req   = '0;
      clear_start = 1'b0;
   endtask

   task automatic do_read(input int lane, input int addr, input logic [DW-1:0] exp);
      read_req[lane]            = 1'b1;
      read_addr[lane*AW +: AW]  = AW'(addr);
      sbq[lane].push_back('{cyc + RL, exp});
   endtask

   task automatic do_write(input int lane, input int addr, input logic [DW-1:0] data);
      write_req[lane]           = 1'b1;
      write_addr[lane*AW +: AW] = AW'(addr);
      write_data[lane*DW +: DW] = data;
   endtask

   // Watches a clear window starting at the cycle where the clear was
   // triggered (k=0); optionally hammers requests that must be dropped.
   task automatic clear_watch(input string tag, input bit poke);
      for (int k = 0; k <= 17; k++) begin
         if (poke && k >= 1 && k <= 16) begin
            for (int l = 0; l < NE; l++) begin
               write_req[l]           = 1'b1;
               write_addr[l*AW +: AW] = '0;
               write_data[l*DW +: DW] = 16'hDEAD;
               read_req[l]            = 1'b1;
               read_addr[l*AW +: AW]  = 4'd2;
            end
         end
         @(negedge clk);
         chk({tag, "_busy"}, 64'(busy), 64'(k >= 1 && k <= 16));
         chk({tag, "_done"}, 64'(clear_done), 64'(k == 17));
         if (poke && k == 1) chk({tag, "_drain_valid"}, 64'(read_valid), 64'(4'b0001));
         if (k < 17) next_cycle();
      end
   endtask

   // Scoreboard: a lane's head entry is due exactly at its cycle.
   always @(negedge clk) begin
      sb_t  e;
      logic exp_v;
      for (int i = 0; i < NE; i++) begin
         exp_v = (sbq[i].size() != 0) && (sbq[i][0].due <= cyc);
         if (read_valid[i] === 1'b1 || exp_v) begin
            chk($sformatf("read_valid_lane%0d", i), 64'(read_valid[i]), 64'(exp_v));
            if (exp_v) begin
               e = sbq[i].pop_front();
               if (read_valid[i] === 1'b1)
                  chk($sformatf("read_data_lane%0d", i), 64'(read_data[i*DW +: DW]), 64'(e.data));
            end
         end
      end
   end

   initial begin
      vecs[0] = '{wr_en:4'b0101, wr_addr:16'h0303, wr_data:64'h0000_1234_0000_A5A5,
                  rd_en:4'b0000, rd_addr:16'h0000, exp_data:64'h0};
      vecs[1] = '{wr_en:4'b0000, wr_addr:16'h0000, wr_data:64'h0,
                  rd_en:4'b1111, rd_addr:16'h3333, exp_data:64'h0000_1234_0000_A5A5};
      vecs[2] = '{wr_en:4'b0010, wr_addr:16'h0070, wr_data:64'h0000_0000_BEEF_0000,
                  rd_en:4'b1011, rd_addr:16'h3077, exp_data:64'h0000_0000_BEEF_0000};
      vecs[3] = '{wr_en:4'b0000, wr_addr:16'h0000, wr_data:64'h0,
                  rd_en:4'b1111, rd_addr:16'h7777, exp_data:64'h0000_0000_BEEF_0000};
      vecs[4] = '{wr_en:4'b1111, wr_addr:16'h9999, wr_data:64'h4004_3003_2002_1001,
                  rd_en:4'b1101, rd_addr:16'h3909, exp_data:64'h0000_3003_0000_1001};
      vecs[5] = '{wr_en:4'b0000, wr_addr:16'h0000, wr_data:64'h0,
                  rd_en:4'b0000, rd_addr:16'h0000, exp_data:64'h0};
      vecs[6] = '{wr_en:4'b0000, wr_addr:16'h0000, wr_data:64'h0,
                  rd_en:4'b1011, rd_addr:16'h9093, exp_data:64'h4004_0000_2002_A5A5};
      vecs[7] = '{wr_en:4'b0100, wr_addr:16'h0300, wr_data:64'h0000_5555_0000_0000,
                  rd_en:4'b0100, rd_addr:16'h0400, exp_data:64'h0};
      vecs[8] = '{wr_en:4'b0000, wr_addr:16'h0000, wr_data:64'h0,
                  rd_en:4'b0100, rd_addr:16'h0300, exp_data:64'h0000_5555_0000_0000};

      // Reset state
      reset = 1'b0;
      repeat (2) next_cycle();
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_clear_done", 64'(clear_done), 64'h0);
      chk("rst_read_valid", 64'(read_valid), 64'h0);
      chk("rst_read_data", read_data, 64'h0);

      // Auto-clear after release, then read addr 5 everywhere
      next_cycle();
      reset = 1'b1;
      clear_watch("auto", 1'b0);
      for (int l = 0; l < NE; l++) do_read(l, 5, 16'h0000);
      next_cycle();

      // Table: lane independence, bypass, no bypass on differing address
      for (int v = 0; v < 9; v++) begin
         write_req  = vecs[v].wr_en;
         write_addr = vecs[v].wr_addr;
         write_data = vecs[v].wr_data;
         for (int l = 0; l < NE; l++)
            if (vecs[v].rd_en[l])
               do_read(l, int'(vecs[v].rd_addr[l*AW +: AW]), vecs[v].exp_data[l*DW +: DW]);
         next_cycle();
      end
      repeat (3) next_cycle();
      @(negedge clk);
      chk("hold_read_valid", 64'(read_valid), 64'h0);
      chk("hold_read_data", read_data, 64'h4004_5555_2002_A5A5);

      // Clear overlapping an in-flight read; requests during busy dropped
      next_cycle();
      do_write(0, 2, 16'h1111);
      next_cycle();
      do_read(0, 2, 16'h1111);
      next_cycle();
      clear_start = 1'b1;
      do_write(1, 2, 16'h7777);
      clear_watch("clear", 1'b1);
      do_read(0, 2, 16'h0000);
      do_read(1, 2, 16'h0000);
      do_read(2, 0, 16'h0000);
      do_read(3, 0, 16'h0000);
      repeat (3) next_cycle();

      // Leave non-zero read_data behind before the reset test
      for (int l = 0; l < NE; l++) do_write(l, 1, 16'hC0DE ^ 16'(l));
      next_cycle();
      for (int l = 0; l < NE; l++) do_read(l, 1, 16'hC0DE ^ 16'(l));
      repeat (3) next_cycle();

      // Reset in the middle of a clear walk (address 8)
      clear_start = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         next_cycle();
         @(negedge clk);
         chk("mid_busy_pre", 64'(busy), 64'h1);
      end
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk("mid_busy_at8", 64'(busy), 64'h1);
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         @(negedge clk);
         chk("mid_rst_busy", 64'(busy), 64'h0);
         chk("mid_rst_done", 64'(clear_done), 64'h0);
         chk("mid_rst_valid", 64'(read_valid), 64'h0);
         chk("mid_rst_data", read_data, 64'h0);
      end
      next_cycle();
      reset = 1'b1;
      clear_watch("reclear", 1'b0);

      // Back-to-back reads on lane 3
      for (int a = 0; a < 16; a++) begin
         do_write(3, a, 16'(a));
         next_cycle();
      end
      for (int a = 0; a < 16; a++) begin
         do_read(3, a, 16'(a));
         next_cycle();
      end
      repeat (4) next_cycle();
      @(negedge clk);
      for (int l = 0; l < NE; l++)
         chk($sformatf("sb_empty_lane%0d", l), 64'(sbq[l].size()), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
